// File: rtl/interrupt_arbiter_if.sv
// Bus bundle between the interrupt pins/software side and the arbiter.
//
// Request handshake: irq_req rises together with a stable irq_vector and stays
// high (vector unchanged) until the cycle irq_ack is sampled high, or until the
// ack timeout expires. A request is transferred on the rising clk edge where
// irq_req=1 and irq_ack=1. irq_ack or rti_done seen while no request / no
// service is outstanding is ignored.
interface interrupt_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int VEC_W   = 3
);
    logic [NUM_SRC-1:0] irq_in;
    logic               mask_we;
    logic [NUM_SRC-1:0] mask_wdata;
    logic               irq_ack;
    logic               rti_done;
    logic               irq_req;
    logic [VEC_W-1:0]   irq_vector;
    logic               in_service;
    logic [NUM_SRC-1:0] pending;
    logic               timeout;
    logic [1:0]         dbg_state;

    modport master (
        output irq_in, mask_we, mask_wdata, irq_ack, rti_done,
        input  irq_req, irq_vector, in_service, pending, timeout, dbg_state
    );

    modport slave (
        input  irq_in, mask_we, mask_wdata, irq_ack, rti_done,
        output irq_req, irq_vector, in_service, pending, timeout, dbg_state
    );
endinterface

// File: rtl/interrupt_arbiter.sv
// Interrupt front end: edge-detects the source lines into a pending latch,
// masks them, picks the lowest-index eligible source and hands it to the
// sequencer with req/ack, then blocks until the service routine returns.
module interrupt_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int VEC_W       = 3,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    interrupt_arbiter_if.slave   bus
);

    // Counter is at least 4 bits and wide enough to hold ACK_TIMEOUT.
    localparam int CLOG_W = $clog2(ACK_TIMEOUT + 1);
    localparam int CNT_W  = (CLOG_W > 4) ? CLOG_W : 4;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] irq_prev_q, irq_prev_d;
    logic               irq_req_q, irq_req_d;
    logic [VEC_W-1:0]   irq_vector_q, irq_vector_d;
    logic               in_service_q, in_service_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [VEC_W-1:0]   winner;

    // Rising-edge detect on the raw lines, eligibility and fixed-priority pick.
    always_comb begin
        rise     = bus.irq_in & ~irq_prev_q;
        eligible = pending_q & mask_q;
        winner   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = VEC_W'(i);
            end
        end
    end

    // Next-state, pending latch, mask and registered outputs.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        irq_req_d    = irq_req_q;
        irq_vector_d = irq_vector_q;
        in_service_d = in_service_q;
        timeout_d    = 1'b0;
        cnt_d        = cnt_q;
        mask_d       = bus.mask_we ? bus.mask_wdata : mask_q;
        irq_prev_d   = bus.irq_in;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // Uses the mask as it stood before any write on this edge.
                if (|eligible) begin
                    state_d      = S_REQ;
                    irq_req_d    = 1'b1;
                    irq_vector_d = winner;
                end
            end
            S_REQ: begin
                if (bus.irq_ack) begin
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (irq_vector_q == VEC_W'(i)) begin
                            pending_d[i] = 1'b0;
                        end
                    end
                    irq_req_d    = 1'b0;
                    in_service_d = 1'b1;
                    state_d      = S_SERVICE;
                end else begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    // Pending bit is kept so the source re-arbitrates.
                    if (cnt_q == CNT_LAST) begin
                        timeout_d = 1'b1;
                        irq_req_d = 1'b0;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_SERVICE: begin
                if (bus.rti_done) begin
                    in_service_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A fresh edge beats a same-cycle clear from the ack.
        pending_d = pending_d | rise;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pending_q    <= '0;
            mask_q       <= '1;
            irq_prev_q   <= '0;
            irq_req_q    <= 1'b0;
            irq_vector_q <= '0;
            in_service_q <= 1'b0;
            timeout_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            irq_prev_q   <= irq_prev_d;
            irq_req_q    <= irq_req_d;
            irq_vector_q <= irq_vector_d;
            in_service_q <= in_service_d;
            timeout_q    <= timeout_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.irq_req    = irq_req_q;
    assign bus.irq_vector = irq_vector_q;
    assign bus.in_service = in_service_q;
    assign bus.pending    = pending_q;
    assign bus.timeout    = timeout_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Bench for interrupt_arbiter: directed scenarios followed by random traffic,
// all checked cycle by cycle against a behavioural model of the arbiter.
module tb_interrupt_arbiter;
    localparam int N  = 4;
    localparam int VW = 3;
    localparam int TO = 15;

    logic clk;
    logic rst_n;

    interrupt_arbiter_if #(.NUM_SRC(N), .VEC_W(VW)) bus ();

    interrupt_arbiter #(.NUM_SRC(N), .VEC_W(VW), .ACK_TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters ----------------
    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Modes: 0 = waiting for work, 1 = requesting, 2 = servicing.
    logic [N-1:0] m_pend, m_mask, m_prev;
    int           m_mode, m_vec, m_wait;
    bit           m_req, m_svc, m_to;
    logic [VW-1:0] exp_q[$];
    bit           prev_svc;

    function automatic void model_reset();
        m_pend = '0; m_mask = '1; m_prev = '0;
        m_mode = 0; m_vec = 0; m_wait = 0;
        m_req = 0; m_svc = 0; m_to = 0;
        exp_q.delete();
        prev_svc = 0;
    endfunction

    function automatic void model_clock();
        int pick;
        pick = -1;
        for (int i = 0; i < N; i++)
            if (pick < 0 && m_pend[i] && m_mask[i]) pick = i;
        m_to = 0;
        if (m_mode == 0) begin
            if (pick >= 0) begin
                m_mode = 1; m_vec = pick; m_req = 1; m_wait = 0;
            end
        end else if (m_mode == 1) begin
            if (bus.irq_ack) begin
                m_pend[m_vec] = 1'b0;
                m_req = 0; m_svc = 1; m_mode = 2;
                exp_q.push_back(VW'(m_vec));
            end else begin
                m_wait++;
                if (m_wait == TO) begin
                    m_to = 1; m_req = 0; m_mode = 0;
                end
            end
        end else begin
            if (bus.rti_done) begin
                m_svc = 0; m_mode = 0;
            end
        end
        for (int i = 0; i < N; i++)
            if (bus.irq_in[i] && !m_prev[i]) m_pend[i] = 1'b1;
        m_prev = bus.irq_in;
        if (bus.mask_we) m_mask = bus.mask_wdata;
    endfunction

    // ---------------- scoreboard / output compare ----------------
    task automatic compare_outputs();
        check_eq("irq_req", 32'(bus.irq_req), 32'(m_req));
        check_eq("pending", 32'(bus.pending), 32'(m_pend));
        check_eq("in_service", 32'(bus.in_service), 32'(m_svc));
        check_eq("timeout", 32'(bus.timeout), 32'(m_to));
        if (m_req || m_svc)
            check_eq("irq_vector", 32'(bus.irq_vector), 32'(m_vec));
        if (bus.in_service && !prev_svc) begin
            check_eq("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                check_eq("sb_vector", 32'(bus.irq_vector), 32'(exp_q.pop_front()));
        end
        prev_svc = bus.in_service;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        if (rst_n) model_clock();
        #1;
        compare_outputs();
    endtask

    task automatic idle_inputs();
        bus.irq_in = '0; bus.mask_we = 0; bus.mask_wdata = '0;
        bus.irq_ack = 0; bus.rti_done = 0;
    endtask

    task automatic pulse_irq(input logic [N-1:0] v);
        bus.irq_in = v; step(); bus.irq_in = '0;
    endtask

    task automatic write_mask(input logic [N-1:0] v);
        bus.mask_we = 1; bus.mask_wdata = v; step(); bus.mask_we = 0;
    endtask

    task automatic do_ack();
        bus.irq_ack = 1; step(); bus.irq_ack = 0;
    endtask

    task automatic do_rti();
        bus.rti_done = 1; step(); bus.rti_done = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        bit seen;
        int ack_pct;
        idle_inputs();
        model_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        step();
        check_eq("rst_pending", 32'(bus.pending), 32'd0);
        check_eq("rst_req", 32'(bus.irq_req), 32'd0);

        // Single source 2 through the full handshake.
        pulse_irq(4'b0100);
        check_eq("p2_pending", 32'(bus.pending), 32'h4);
        check_eq("p2_req_early", 32'(bus.irq_req), 32'd0);
        step();
        check_eq("p2_req", 32'(bus.irq_req), 32'd1);
        check_eq("p2_vec", 32'(bus.irq_vector), 32'd2);
        step();
        do_ack();
        check_eq("p2_ack_pend", 32'(bus.pending), 32'd0);
        check_eq("p2_ack_svc", 32'(bus.in_service), 32'd1);
        check_eq("p2_ack_req", 32'(bus.irq_req), 32'd0);
        step(); step();
        do_rti();
        check_eq("p2_rti_svc", 32'(bus.in_service), 32'd0);

        // Sources 1 and 3 together: 1 first, then 3 one cycle after RTI.
        pulse_irq(4'b1010);
        step();
        check_eq("pri_vec1", 32'(bus.irq_vector), 32'd1);
        do_ack();
        step();
        do_rti();
        check_eq("pri_gap", 32'(bus.irq_req), 32'd0);
        step();
        check_eq("pri_req3", 32'(bus.irq_req), 32'd1);
        check_eq("pri_vec3", 32'(bus.irq_vector), 32'd3);
        do_ack();
        do_rti();

        // Masked source 0 waits until unmasked.
        write_mask(4'b1110);
        pulse_irq(4'b0001);
        repeat (3) begin
            step();
            check_eq("mask_noreq", 32'(bus.irq_req), 32'd0);
        end
        write_mask(4'b1111);
        step();
        check_eq("unmask_req", 32'(bus.irq_req), 32'd1);
        check_eq("unmask_vec", 32'(bus.irq_vector), 32'd0);
        do_ack();
        do_rti();

        // Ack timeout on source 1.
        pulse_irq(4'b0010);
        step();
        check_eq("to_req", 32'(bus.irq_req), 32'd1);
        k = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (bus.timeout) seen = 1;
            else k++;
        end
        check_eq("to_seen", 32'(seen), 32'd1);
        check_eq("to_len", 32'(k), 32'(TO - 1));
        check_eq("to_req_drop", 32'(bus.irq_req), 32'd0);
        check_eq("to_pend_kept", 32'(bus.pending[1]), 32'd1);
        step();
        check_eq("to_once", 32'(bus.timeout), 32'd0);
        check_eq("to_rearm", 32'(bus.irq_req), 32'd1);
        do_ack();
        do_rti();

        // Async reset in the middle of a service with 1010 pending.
        pulse_irq(4'b0001);
        step();
        do_ack();
        write_mask(4'b0000);
        pulse_irq(4'b1010);
        check_eq("rs_pend", 32'(bus.pending), 32'hA);
        check_eq("rs_svc", 32'(bus.in_service), 32'd1);
        #2 rst_n = 0;
        #1;
        model_reset();
        check_eq("rs_async_pend", 32'(bus.pending), 32'd0);
        check_eq("rs_async_svc", 32'(bus.in_service), 32'd0);
        check_eq("rs_async_req", 32'(bus.irq_req), 32'd0);
        check_eq("rs_async_vec", 32'(bus.irq_vector), 32'd0);
        step();
        #1 rst_n = 1;
        repeat (3) begin
            step();
            check_eq("rs_quiet", 32'(bus.irq_req), 32'd0);
        end
        pulse_irq(4'b0100);
        step();
        check_eq("rs_mask_ones", 32'(bus.irq_req), 32'd1);
        do_ack();
        do_rti();

        // Random traffic.
        ack_pct = 40;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) ack_pct = $urandom_range(3, 60);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 7) == 0) bus.irq_in[i] = ~bus.irq_in[i];
            bus.mask_we = ($urandom_range(0, 19) == 0);
            bus.mask_wdata = N'($urandom);
            if (m_req) bus.irq_ack = ($urandom_range(0, 99) < ack_pct);
            else       bus.irq_ack = ($urandom_range(0, 15) == 0);
            if (m_svc) bus.rti_done = ($urandom_range(0, 3) == 0);
            else       bus.rti_done = ($urandom_range(0, 15) == 0);
            step();
        end
        idle_inputs();
        step();
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
